// File: rtl/ula_contention_sched.sv
// ula_contention_sched: Z80 clock-enable generator with 48K raster tracking,
// ULA memory contention and frame interrupt. Runs entirely on clk_main.
module ula_contention_sched #(
  parameter int DIV_NORMAL      = 8,
  parameter int DIV_TURBO       = 4,
  parameter int TS_PER_LINE     = 224,
  parameter int LINES_PER_FRAME = 312,
  parameter int CONT_FIRST_LINE = 64,
  parameter int CONT_LINES      = 192,
  parameter int CONT_TS         = 128,
  parameter int INT_LEN         = 32
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic       cpu_turbo,
  input  logic       cont_enable,
  input  logic       cont_req,
  output logic       cpu_ce,
  output logic       cpu_stall,
  output logic       int_n,
  output logic       frame_start,
  output logic [8:0] tstate,
  output logic [8:0] line
);

  localparam int PSW = (DIV_NORMAL > 1) ? $clog2(DIV_NORMAL) : 1;

  localparam logic [PSW-1:0] PS_LAST_N = PSW'(DIV_NORMAL - 1);
  localparam logic [PSW-1:0] PS_LAST_T = PSW'(DIV_TURBO - 1);
  localparam logic [8:0]     TS_LAST   = 9'(TS_PER_LINE - 1);
  localparam logic [8:0]     LINE_LAST = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0]     CONT_LO   = 9'(CONT_FIRST_LINE);
  localparam logic [8:0]     CONT_HI   = 9'(CONT_FIRST_LINE + CONT_LINES - 1);
  localparam logic [8:0]     CONT_TSL  = 9'(CONT_TS);
  localparam logic [8:0]     INT_TSL   = 9'(INT_LEN);

  logic [PSW-1:0] ps;
  logic           turbo_sel;   // divider choice, only changes at a T-state boundary
  logic [2:0]     stall_cnt;   // T-states still to withhold after the first one
  logic           served;      // current request already had its contention
  logic           tick;
  logic           win;
  logic [2:0]     delay;

  // Decode the T-state tick, the contention window and the ULA delay for this T-state.
  always_comb begin
    tick = 1'b0;
    if (turbo_sel) begin
      tick = (ps == PS_LAST_T);
    end else begin
      tick = (ps == PS_LAST_N);
    end
    win = !cpu_turbo && cont_enable &&
          (line >= CONT_LO) && (line <= CONT_HI) && (tstate < CONT_TSL);
    case (tstate[2:0])
      3'd0:    delay = 3'd6;
      3'd1:    delay = 3'd5;
      3'd2:    delay = 3'd4;
      3'd3:    delay = 3'd3;
      3'd4:    delay = 3'd2;
      3'd5:    delay = 3'd1;
      default: delay = 3'd0;
    endcase
  end

  // Prescaler and raster position; frame_start marks the wrap to line 0 / tstate 0.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      ps          <= '0;
      turbo_sel   <= cpu_turbo;
      tstate      <= 9'd0;
      line        <= 9'd0;
      frame_start <= 1'b0;
    end else if (tick) begin
      ps          <= '0;
      turbo_sel   <= cpu_turbo;
      frame_start <= 1'b0;
      if (tstate == TS_LAST) begin
        tstate <= 9'd0;
        if (line == LINE_LAST) begin
          line        <= 9'd0;
          frame_start <= 1'b1;
        end else begin
          line <= line + 9'd1;
        end
      end else begin
        tstate <= tstate + 9'd1;
      end
    end else begin
      ps          <= ps + PSW'(1);
      frame_start <= 1'b0;
    end
  end

  // Contention arbiter: grant or withhold one CPU T-state per tick.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      cpu_ce    <= 1'b0;
      cpu_stall <= 1'b0;
      stall_cnt <= 3'd0;
      served    <= 1'b0;
    end else begin
      // A request is marked served at the first tick it sees with no stall running.
      served <= cont_req && (served || (tick && (stall_cnt == 3'd0)));
      if (!tick) begin
        cpu_ce <= 1'b0;
      end else if (stall_cnt != 3'd0) begin
        cpu_ce    <= 1'b0;
        stall_cnt <= stall_cnt - 3'd1;
        cpu_stall <= (stall_cnt != 3'd1);
      end else if (cont_req && !served && win && (delay != 3'd0)) begin
        cpu_ce    <= 1'b0;
        stall_cnt <= delay - 3'd1;
        cpu_stall <= (delay > 3'd1);
      end else begin
        cpu_ce    <= 1'b1;
        cpu_stall <= 1'b0;
      end
    end
  end

  // Frame interrupt: low for the first INT_LEN T-states of line 0.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      int_n <= 1'b1;
    end else begin
      int_n <= !((line == 9'd0) && (tstate < INT_TSL));
    end
  end

endmodule
